// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the SPI arbiter: FSM state encoding,
// the number of SCLK half-periods per byte and the slow-rate multiplier.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One byte takes 8 SCLK periods, i.e. 16 half-periods.
  localparam int HALF_PERIODS = 16;

  // Slow half-period = SLOW_MULT microseconds (250 kHz SCLK).
  localparam int SLOW_MULT = 2;

endpackage

// File: rtl/spi_arbiter_shifter.sv
// SPI mode-0 byte engine: half-period divider, half-period counter and
// transmit/receive shift registers. Started by a one-cycle start_i pulse,
// it raises done_o on the cycle whose edge ends the 16th half-period.
module spi_arbiter_shifter
  import spi_arbiter_pkg::*;
#(
  parameter int CLK_TICKS_PER_USEC = 100,
  parameter int FAST_HALF          = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       fast_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic [7:0] rx_o
);

  localparam int SLOW_HALF = SLOW_MULT * CLK_TICKS_PER_USEC;
  localparam int MAX_HALF  = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int DW        = $clog2(MAX_HALF + 2);
  localparam int HW        = $clog2(HALF_PERIODS);

  localparam logic [DW-1:0] FAST_LOAD = DW'(FAST_HALF);
  localparam logic [DW-1:0] SLOW_LOAD = DW'(SLOW_HALF);

  logic          active_q;
  logic          fast_q;
  logic [DW-1:0] div_q;
  logic [HW-1:0] half_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic          sclk_q;
  logic          half_end;
  logic [DW-1:0] reload;

  assign reload   = fast_q ? FAST_LOAD : SLOW_LOAD;
  assign half_end = active_q && (div_q == DW'(1));
  assign done_o   = half_end && (half_q == HW'(HALF_PERIODS - 1));

  // MOSI idles high; while shifting it always shows the current MSB.
  assign mosi_o = active_q ? tx_q[7] : 1'b1;
  assign sclk_o = sclk_q;
  assign rx_o   = rx_q;

  // Divider, half-period counter and shift registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      fast_q   <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
    end else if (start_i) begin
      // One extra tick before the first half-period gives MOSI a setup cycle.
      active_q <= 1'b1;
      fast_q   <= fast_i;
      div_q    <= (fast_i ? FAST_LOAD : SLOW_LOAD) + DW'(1);
      half_q   <= '0;
      tx_q     <= data_i;
      sclk_q   <= 1'b0;
    end else if (half_end) begin
      div_q  <= reload;
      half_q <= half_q + HW'(1);
      if (!half_q[0]) begin
        // End of an odd half-period: rising SCLK, sample MISO.
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], miso_i};
      end else begin
        // End of an even half-period: falling SCLK, present next bit.
        sclk_q <= 1'b0;
        tx_q   <= {tx_q[6:0], 1'b0};
      end
      if (done_o) active_q <= 1'b0;
    end else if (active_q) begin
      div_q <= div_q - DW'(1);
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Multi-client SPI arbiter with toggle req/ack handshake and round-robin
// grant. Optional grant locking is enabled by defining SPI_ARBITER_LOCK_EN;
// without it the lock port is accepted and ignored.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int CHANNELS           = 2,
  parameter int CLK_TICKS_PER_USEC = 100,
  parameter int FAST_HALF          = 2,
  localparam int OW                = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   req,
  output logic [CHANNELS-1:0]   ack,
  input  logic [CHANNELS*8-1:0] d,
  input  logic [CHANNELS-1:0]   speed,
  input  logic [CHANNELS-1:0]   lock,
  output logic [7:0]            q,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] ack_q;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] elig;
  logic [7:0]          q_q;
  logic [7:0]          tx_byte;
  logic [7:0]          rx_byte;
  logic [OW-1:0]       owner_q;
  logic [OW-1:0]       rr_q;
  logic [OW-1:0]       gidx;
  logic [OW-1:0]       rr_next;
  logic                lat_req_q;
  logic                grant;
  logic                found;
  logic                tx_fast;
  logic                sh_done;
  int                  idx;

`ifdef SPI_ARBITER_LOCK_EN
  logic holder_q;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  assign ack   = ack_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

  // Pending detection, round-robin search and FSM next state.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    pend    = req ^ ack_q;
    elig    = pend;
    gidx    = rr_q;
    found   = 1'b0;
    idx     = 0;
    grant   = 1'b0;
    state_d = state_q;
`ifdef SPI_ARBITER_LOCK_EN
    // A held grant restricts eligibility to the previous owner.
    if (holder_q && lock[owner_q]) begin
      elig          = '0;
      elig[owner_q] = pend[owner_q];
    end
`endif
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = OW'(idx);
      end
    end
    rr_next = (int'(gidx) == CHANNELS - 1) ? '0 : gidx + OW'(1);
    tx_byte = d[8*int'(gidx) +: 8];
    tx_fast = speed[gidx];
    case (state_q)
      IDLE: begin
        if (found) begin
          grant   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT:   if (sh_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant bookkeeping and the ack/q update that closes a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      q_q       <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      lat_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q   <= gidx;
        rr_q      <= rr_next;
        lat_req_q <= req[gidx];
      end
      if (state_q == DONE) begin
        ack_q[owner_q] <= lat_req_q;
        q_q            <= rx_byte;
      end
    end
  end

`ifdef SPI_ARBITER_LOCK_EN
  // Lock holder: armed when a transfer ends with lock[owner] high, released
  // once that client drops lock while the arbiter is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holder_q <= 1'b0;
    end else if (state_q == DONE) begin
      holder_q <= lock[owner_q];
    end else if (state_q == IDLE && !lock[owner_q]) begin
      holder_q <= 1'b0;
    end
  end
`endif

  spi_arbiter_shifter #(
    .CLK_TICKS_PER_USEC(CLK_TICKS_PER_USEC),
    .FAST_HALF         (FAST_HALF)
  ) u_shifter (
    .clk    (clk),
    .reset_n(reset_n),
    .start_i(grant),
    .data_i (tx_byte),
    .fast_i (tx_fast),
    .miso_i (miso),
    .sclk_o (sclk),
    .mosi_o (mosi),
    .done_o (sh_done),
    .rx_o   (rx_byte)
  );

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of SPI client ports (1..8).
REQ-002 SHALL have parameter CLK_TICKS_PER_USEC, default 100, clk cycles per microsecond.
REQ-003 SHALL have parameter FAST_HALF, default 2, clk cycles per SCLK half-period in fast mode (>=1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  CHANNELS  per-client toggle request; pending when req[i] != ack[i].
REQ-007 SHALL have port ack  output  CHANNELS  per-client toggle acknowledge.
REQ-008 SHALL have port d  input  CHANNELS*8  per-client transmit byte, client i at bits [8i+7:8i].
REQ-009 SHALL have port speed  input  CHANNELS  per-client rate: 1 fast, 0 slow.
REQ-010 SHALL have port lock  input  CHANNELS  per-client grant hold (see Configuration).
REQ-011 SHALL have port q  output  8  received byte of the last completed transfer, shared by all clients.
REQ-012 SHALL have ports sclk output 1, mosi output 1, miso input 1  SPI mode 0 lines.
REQ-013 SHALL have port owner  output  clog2(CHANNELS) (min 1)  index of current/last granted client.
REQ-014 SHALL have port busy  output  1  high from grant until ack toggle.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on grant, SHIFT->DONE after 16 half-periods, DONE->IDLE after one cycle.
REQ-016 In IDLE with any pending client, SHALL grant in one cycle by round-robin starting at the channel after the last granted one (pointer resets to 0).
REQ-017 At grant SHALL latch d, speed and req value of the granted client; later changes to those inputs SHALL not affect the transfer.
REQ-018 Half-period H SHALL be FAST_HALF when latched speed=1, else 2*CLK_TICKS_PER_USEC (250 kHz SCLK).
REQ-019 Transfer SHALL be 8 bits MSB first: mosi valid from grant+1, sclk rising after each odd half-period, miso sampled on that rising edge, mosi updated on falling edge.
REQ-020 sclk SHALL be 0 and mosi 1 whenever not in SHIFT.
REQ-021 For req toggle sampled at edge 0 in IDLE, ack SHALL toggle (become equal to latched req) and q update at edge 2+16*H; busy falls the same edge.
REQ-022 A second req toggle by a client before its grant SHALL cancel the request (req==ack); one after grant SHALL be pending for a new transfer after ack.
REQ-023 Simultaneous pending requests SHALL be served one byte each in round-robin order; no client SHALL wait more than CHANNELS-1 transfers (lock disabled).
REQ-024 ack bits of non-granted clients SHALL never change.

Reset
REQ-025 On reset_n low, asynchronously: state IDLE, ack all 0, q 0x00, sclk 0, mosi 1, busy 0, owner 0, round-robin pointer 0, lock holder cleared.
REQ-026 Reset mid-transfer SHALL abort without ack toggle; after release, clients with req=1 SHALL be pending.

Configuration
REQ-027 Macro SPI_ARBITER_LOCK_EN SHALL enable grant locking.
REQ-028 With SPI_ARBITER_LOCK_EN: after a transfer, if lock[owner]=1, the next grant SHALL go only to owner (others wait) until lock[owner] is 0 in IDLE; round-robin resumes after owner.
REQ-029 Without SPI_ARBITER_LOCK_EN: lock port SHALL be present and ignored; pure round-robin.

Structure
REQ-030 Package spi_arbiter_pkg SHALL hold the state enum, SHIFT half-period count (16) and the slow-divider multiplier (2).
REQ-031 Sub-module spi_arbiter_shifter SHALL contain divider, bit counter and shift register; spi_arbiter contains arbitration and handshake.

Verification
REQ-032 Fast single: CHANNELS=2, FAST_HALF=2, ch0 d=0xA5 speed=1, miso loops mosi -> mosi 1010_0101 on 8 rising edges, ack[0] toggles at cycle 34, q=0xA5.
REQ-033 Slow: CLK_TICKS_PER_USEC=100, speed=0, d=0xFF, miso=0 -> sclk half-period 200 cycles, ack at cycle 3202, q=0x00.
REQ-034 Contention: ch0 and ch1 toggle same cycle after reset, 3 times each -> owner sequence 0,1,0,1,0,1.
REQ-035 Cancel: ch1 toggles twice while ch0 transfer runs -> no ch1 transfer, ack[1] unchanged.
REQ-036 Reset mid-transfer: reset_n low at bit 4 -> sclk 0, mosi 1, ack 0, q 0x00 immediately; after release req[0]=1 re-served.
REQ-037 Lock (macro defined): lock[0]=1, ch0 and ch1 pending continuously -> ch0 served 3 times, lock[0]=0, then ch1 served next.
